// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with a transmit FIFO and a configurable
// frame format (data width, optional odd/even parity, one or two stop bits).
// Frames are drained from the FIFO back-to-back with no idle gap.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 896,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int DEPTH        = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_BITS-1:0]           in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           tx,
  output logic                           busy,
  output logic                           tx_done,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Parity bit sent on the line: odd mode makes total ones odd, even mode even.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
    if (PARITY == 1) begin
      return ~^data;
    end else begin
      return ^data;
    end
  endfunction

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [2:0]           r_state;
  logic [BW-1:0]        r_baud;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_baud_end;
  logic [DATA_BITS-1:0] w_head;
  logic [2:0]           w_state_nx;
  logic [BW-1:0]        w_baud_nx;
  logic [3:0]           w_bit_nx;
  logic [DATA_BITS-1:0] w_shift_nx;
  logic                 w_par_nx;
  logic                 w_tx_nx;
  logic                 w_done_nx;

  assign in_ready   = ~rst && (r_count < CNT_FULL);
  assign w_push     = in_valid && in_ready;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_baud_end = (r_baud == BAUD_LAST);

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign tx_done    = r_done;
  assign fifo_count = r_count;

  // Next-state logic for the frame sequencer, including FIFO pop decisions.
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = w_baud_end ? '0 : (r_baud + BAUD_ONE);
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_par_nx   = r_par;
    w_pop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nx = '0;
        if (r_count != '0) begin
          w_pop      = 1'b1;
          w_state_nx = S_START;
          w_bit_nx   = 4'd0;
          w_shift_nx = w_head;
          w_par_nx   = parity_bit(w_head);
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_nx = S_DATA;
          w_bit_nx   = 4'd0;
        end else begin
          w_state_nx = S_START;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_shift_nx = r_shift >> 1;
          if (r_bit == DATA_LAST) begin
            w_bit_nx   = 4'd0;
            w_state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_nx = r_bit + 4'd1;
          end
        end else begin
          w_state_nx = S_DATA;
        end
      end
      S_PARITY: begin
        if (w_baud_end) begin
          w_state_nx = S_STOP;
          w_bit_nx   = 4'd0;
        end else begin
          w_state_nx = S_PARITY;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          if (r_bit == STOP_LAST) begin
            w_bit_nx = 4'd0;
            if (r_count != '0) begin
              // Chain straight into the next frame: no idle cycle.
              w_pop      = 1'b1;
              w_state_nx = S_START;
              w_shift_nx = w_head;
              w_par_nx   = parity_bit(w_head);
            end else begin
              w_state_nx = S_IDLE;
            end
          end else begin
            w_bit_nx = r_bit + 4'd1;
          end
        end else begin
          w_state_nx = S_STOP;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_baud_nx  = '0;
        w_bit_nx   = 4'd0;
      end
    endcase
  end

  // Line level and done pulse for the cycle that follows the next edge.
  always_comb begin
    case (w_state_nx)
      S_IDLE:   w_tx_nx = 1'b1;
      S_START:  w_tx_nx = 1'b0;
      S_DATA:   w_tx_nx = w_shift_nx[0];
      S_PARITY: w_tx_nx = w_par_nx;
      S_STOP:   w_tx_nx = 1'b1;
      default:  w_tx_nx = 1'b1;
    endcase
    w_done_nx = (w_state_nx == S_STOP) && (w_baud_nx == BAUD_LAST) &&
                (w_bit_nx == STOP_LAST);
  end

  // FIFO storage write; contents are don't-care once count is cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer state and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 4'd0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_par   <= w_par_nx;
      r_tx    <= w_tx_nx;
      r_busy  <= (w_state_nx != S_IDLE);
      r_done  <= w_done_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed bench for uart_tx_cfg over several frame formats.
module tb_uart_tx_cfg;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic [4:0] v;
  logic [4:0] tx_v, busy_v, done_v, rdy_v;
  logic [3:0] cnt0, cnt1, cnt2, cnt3;
  logic [2:0] cnt4;

  logic [2:0] sel;
  logic       m_tx, m_busy, m_done, m_rdy;
  logic [3:0] m_cnt;

  int n_chk;
  int n_err;

  uart_tx_cfg #(.CLKS_PER_BIT(4)) u0 (
    .clk(clk), .rst(rst), .in_data(d), .in_valid(v[0]), .in_ready(rdy_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]), .fifo_count(cnt0));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .PARITY(2)) u1 (
    .clk(clk), .rst(rst), .in_data(d), .in_valid(v[1]), .in_ready(rdy_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]), .fifo_count(cnt1));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .PARITY(1)) u2 (
    .clk(clk), .rst(rst), .in_data(d), .in_valid(v[2]), .in_ready(rdy_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]), .fifo_count(cnt2));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(5), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .in_data(d[4:0]), .in_valid(v[3]), .in_ready(rdy_v[3]),
    .tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]), .fifo_count(cnt3));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .in_data(d), .in_valid(v[4]), .in_ready(rdy_v[4]),
    .tx(tx_v[4]), .busy(busy_v[4]), .tx_done(done_v[4]), .fifo_count(cnt4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the selected instance onto common observation signals.
  always_comb begin
    m_tx   = tx_v[sel];
    m_busy = busy_v[sel];
    m_done = done_v[sel];
    m_rdy  = rdy_v[sel];
    case (sel)
      3'd0:    m_cnt = cnt0;
      3'd1:    m_cnt = cnt1;
      3'd2:    m_cnt = cnt2;
      3'd3:    m_cnt = cnt3;
      3'd4:    m_cnt = {1'b0, cnt4};
      default: m_cnt = cnt0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Single push into an idle instance; returns at the first start-bit cycle.
  task automatic push_one(input logic [2:0] s, input logic [7:0] data, input string tag);
    sel = s;
    @(negedge clk);
    d = data;
    v[s] = 1'b1;
    @(posedge clk);
    #1;
    v[s] = 1'b0;
    @(negedge clk);
    chk({tag, "_cnt_after_push"}, m_cnt, 1);
    chk({tag, "_tx_idle"}, m_tx, 1);
    chk({tag, "_busy_idle"}, m_busy, 0);
    @(negedge clk);
    chk({tag, "_cnt_after_pop"}, m_cnt, 0);
    chk({tag, "_tx_start"}, m_tx, 0);
    chk({tag, "_busy_start"}, m_busy, 1);
  endtask

  // Check one frame of nb bit periods (4 clocks each), bits[0] = start bit.
  task automatic frame(input string tag, input logic [15:0] bits, input int nb);
    int ok;
    int bz;
    int dn;
    int dpos;
    bz = 0;
    dn = 0;
    dpos = -1;
    for (int b = 0; b < nb; b++) begin
      ok = 0;
      for (int c = 0; c < 4; c++) begin
        if (m_tx === bits[b]) ok++;
        if (m_busy === 1'b1) bz++;
        if (m_done === 1'b1) begin
          dn++;
          dpos = b * 4 + c;
        end
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, b), ok, 4);
    end
    chk({tag, "_busy_cycles"}, bz, nb * 4);
    chk({tag, "_done_pulses"}, dn, 1);
    chk({tag, "_done_pos"}, dpos, nb * 4 - 1);
  endtask

  logic [7:0] b4 [6];
  logic       rec [220];

  initial begin
    int idx;
    int t;
    int good;
    logic hs;
    n_chk = 0;
    n_err = 0;
    sel = 3'd0;
    d = 8'h00;
    v = 5'b0;
    rst = 1'b1;
    b4[0] = 8'h31; b4[1] = 8'h32; b4[2] = 8'h33;
    b4[3] = 8'h34; b4[4] = 8'h35; b4[5] = 8'h36;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", m_tx, 1);
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_cnt", m_cnt, 0);
    chk("rst_ready", m_rdy, 0);
    rst = 1'b0;
    #1;
    chk("rel_ready", m_rdy, 1);

    // 8N1, 0xA5
    push_one(3'd0, 8'hA5, "a5");
    frame("a5", {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
    chk("a5_after_busy", m_busy, 0);
    chk("a5_after_tx", m_tx, 1);

    // Parity variants
    push_one(3'd1, 8'h55, "ev55");
    frame("ev55", {5'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11);
    push_one(3'd2, 8'h55, "od55");
    frame("od55", {5'b0, 1'b1, 1'b1, 8'h55, 1'b0}, 11);
    push_one(3'd2, 8'h07, "od07");
    frame("od07", {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);

    // 5 data bits, 2 stop bits
    push_one(3'd3, 8'h1F, "d5s2");
    frame("d5s2", {8'b0, 2'b11, 5'h1F, 1'b0}, 8);
    chk("d5s2_after_busy", m_busy, 0);
    chk("d5s2_after_tx", m_tx, 1);

    // Push during a frame, then push coinciding with the chained pop
    push_one(3'd0, 8'h11, "p11");
    d = 8'h22;
    v[0] = 1'b1;
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    @(negedge clk);
    chk("p22_cnt", m_cnt, 1);
    t = 0;
    while (m_done !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("p11_done_seen", m_done, 1);
    d = 8'h33;
    v[0] = 1'b1;
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    @(negedge clk);
    chk("pp_cnt_same_edge", m_cnt, 1);
    chk("pp_tx_nogap", m_tx, 0);
    chk("pp_busy", m_busy, 1);
    frame("f22", {6'b0, 1'b1, 8'h22, 1'b0}, 10);
    chk("f33_cnt", m_cnt, 0);
    chk("f33_tx_nogap", m_tx, 0);
    frame("f33", {6'b0, 1'b1, 8'h33, 1'b0}, 10);
    chk("f33_after_busy", m_busy, 0);

    // Reset mid-DATA with three bytes queued
    sel = 3'd0;
    @(negedge clk);
    v[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 8'h01 + 8'(i);
      @(posedge clk);
      #1;
    end
    v[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_cnt", m_cnt, 3);
    chk("mid_busy", m_busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", m_rdy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tx", m_tx, 1);
    chk("abort_busy", m_busy, 0);
    chk("abort_cnt", m_cnt, 0);
    chk("abort_ready", m_rdy, 1);
    good = 0;
    for (int i = 0; i < 60; i++) begin
      if (m_tx === 1'b1 && m_busy === 1'b0) good++;
      @(negedge clk);
    end
    chk("abort_quiet", good, 60);

    // DEPTH=4, in_valid held for 10 cycles with 6 distinct bytes
    sel = 3'd4;
    idx = 0;
    for (int n = 0; n < 220; n++) begin
      @(negedge clk);
      rec[n] = m_tx;
      if (n == 5 || n == 9) begin
        chk($sformatf("full_cnt_n%0d", n), m_cnt, 4);
        chk($sformatf("full_ready_n%0d", n), m_rdy, 0);
      end
      if (n < 10 && idx < 6) begin
        d = b4[idx];
        v[4] = 1'b1;
        hs = m_rdy;
      end else begin
        v[4] = 1'b0;
        hs = 1'b0;
      end
      if (hs) idx++;
    end
    chk("full_accepted", idx, 5);
    chk("full_rec_idle0", rec[0], 1);
    chk("full_rec_idle1", rec[1], 1);
    for (int f = 0; f < 5; f++) begin
      logic [9:0] fb;
      fb = {1'b1, b4[f], 1'b0};
      for (int b = 0; b < 10; b++) begin
        good = 0;
        for (int c = 0; c < 4; c++) begin
          if (rec[2 + f * 40 + b * 4 + c] === fb[b]) good++;
        end
        chk($sformatf("full_f%0d_bit%0d", f, b), good, 4);
      end
    end
    good = 0;
    for (int n = 202; n < 220; n++) begin
      if (rec[n] === 1'b1) good++;
    end
    chk("full_tail_idle", good, 18);
    chk("full_end_busy", m_busy, 0);
    chk("full_end_cnt", m_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
